// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 block sequencer: FSM encoding, bus widths, defaults.
package sha256_pkg;

  localparam int BLK_W       = 512;
  localparam int DIG_W       = 256;
  localparam int TIMEOUT_DEF = 128;

  typedef logic [BLK_W-1:0] blk_t;
  typedef logic [DIG_W-1:0] dig_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    NEXT  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/sha256_H_0.sv
// SHA-256 initial chaining value H0; pure constant, no latency, no flow control.
module sha256_H_0
  import sha256_pkg::*;
(
  output dig_t H_0
);

  assign H_0 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

endmodule

// File: rtl/sha256_seq.sv
// Feeds padded blocks through an external SHA-256 core and returns the message digest.
// Per block: 1 accept + 1 issue cycle + core latency; blk_ready only in IDLE/NEXT, digest held until digest_ready.
module sha256_seq
  import sha256_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic [BLK_W-1:0] blk_data,
  input  logic             blk_last,
  output logic             digest_valid,
  input  logic             digest_ready,
  output logic [DIG_W-1:0] digest,
  output logic [DIG_W-1:0] core_H_in,
  output logic [BLK_W-1:0] core_M_in,
  output logic             core_input_valid,
  input  logic [DIG_W-1:0] core_H_out,
  input  logic             core_output_valid,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] blk_count
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state, state_nxt;
  dig_t             h0;
  dig_t             h_reg;
  blk_t             m_reg;
  logic             last_reg;
  logic [TMR_W-1:0] timer;
  logic             blk_xfer;
  logic             core_done;
  logic             core_tmo;

  sha256_H_0 u_h0 (.H_0(h0));

  assign blk_ready        = (state == IDLE) || (state == NEXT);
  assign blk_xfer         = blk_valid && blk_ready;
  assign core_done        = (state == WAIT) && core_output_valid;
  // Last WAIT cycle: the core has had TIMEOUT_CYCLES cycles since ISSUE.
  assign core_tmo         = (state == WAIT) && !core_output_valid &&
                            (timer == TMR_W'(TIMEOUT_CYCLES - 1));

  assign core_input_valid = (state == ISSUE);
  assign core_H_in        = h_reg;
  assign core_M_in        = m_reg;
  assign digest_valid     = (state == DONE);
  assign digest           = h_reg;
  assign busy             = (state != IDLE);
  assign timeout_err      = core_tmo;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, NEXT: if (blk_xfer) state_nxt = ISSUE;
      ISSUE:      state_nxt = WAIT;
      WAIT: begin
        if (core_done)     state_nxt = last_reg ? DONE : NEXT;
        else if (core_tmo) state_nxt = IDLE;
      end
      DONE:       if (digest_ready) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_reg     <= h0;
      m_reg     <= '0;
      last_reg  <= 1'b0;
      timer     <= '0;
      blk_count <= '0;
    end else begin
      if (blk_xfer) begin
        m_reg    <= blk_data;
        last_reg <= blk_last;
        // A new message always restarts the chain from H0.
        if (state == IDLE) begin
          h_reg     <= h0;
          blk_count <= '0;
        end
      end
      if (state == ISSUE)     timer <= '0;
      else if (state == WAIT) timer <= timer + TMR_W'(1);
      if (core_done) begin
        h_reg <= core_H_out;
        if (blk_count != {CNT_W{1'b1}}) blk_count <= blk_count + CNT_W'(1);
      end
    end
  end

endmodule
